fp_mul_iter: RTL and testbench
==============================

// Module: fp_mul_iter
// PURPOSE
//  Parametrised, multi-cycle IEEE-754-style floating-point multiplier.
//  Successor to the combinational FPU mul function: adds valid/ready handshakes and an iterative radix-2^RADIX_BITS
//  mantissa multiplier, plus round-to-nearest-even, special-value handling and exception flags.
//  Sits in the FPU execute stage; one operation in flight at a time.
// PARAMETERS
//  EXP_BITS   8   exponent width; bias = 2**(EXP_BITS-1)-1
//  MAN_BITS   23  stored fraction width (implicit one excluded)
//  RADIX_BITS 4   multiplier bits retired per MULT cycle (1..MAN_BITS+1)
// PORTS (W = 1+EXP_BITS+MAN_BITS, packed {s,e,m})
//  i_clk     in   1  clock, rising edge
//  i_rst     in   1  reset, synchronous, active-high
//  i_valid   in   1  operands valid
//  o_ready   out  1  block can accept operands
//  i_a       in   W  operand X
//  i_b       in   W  operand Y
//  o_valid   out  1  result valid
//  i_ready   in   1  consumer accepts result
//  o_result  out  W  product
//  o_flags   out  4  {invalid,overflow,underflow,inexact} (FPU_MUL_FLAGS_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, o_valid=0, o_ready=1, o_result=0, o_flags=0; reset mid-op drops the op, no output.
//  o_ready = (state==IDLE) | (state==DONE & i_ready); accept on i_valid&o_ready, latch i_a/i_b.
//  FSM: IDLE -accept-> CLASS -> MULT (N=ceil((MAN_BITS+1)/RADIX_BITS) cycles) -> NORM -> ROUND -> DONE.
//   CLASS short-circuits specials straight to DONE with final result (latency 2).
//   DONE: o_valid=1, o_result/o_flags stable until i_ready; i_ready&i_valid same cycle -> CLASS (back-to-back),
//   i_ready only -> IDLE.
//  Normal latency accept->o_valid = N+4 cycles (binary32, RADIX_BITS=4: N=6, latency 10).
//  Classification (FTZ): e==0 -> zero (fraction ignored); e==all-ones,m==0 -> inf; e==all-ones,m!=0 -> NaN.
//  Specials: any NaN or 0*inf -> canonical qNaN {0,all-ones,1<<(MAN_BITS-1)}, invalid=1.
//   inf*finite/inf -> {sx^sy,all-ones,0}; zero*finite -> {sx^sy,0,0}; no other flags.
//  MULT: ma={1,mx}, mb={1,my}; acc(2*MAN_BITS+2 b) += (ma * mb[RADIX_BITS-1:0]) << k*RADIX_BITS;
//   mb >>= RADIX_BITS per cycle; last chunk zero-padded.
//  Exponent: signed EXP_BITS+2 b, e = ex+ey-bias; s = sx^sy.
//  NORM: if acc MSB set -> e+=1, keep top MAN_BITS+1; else shift 1 left. guard=next bit, sticky=OR of rest.
//  ROUND (RNE): up if guard&(sticky|lsb); carry-out of mantissa -> m=0, e+=1. inexact=guard|sticky.
//  Final e >= 2**EXP_BITS-1 -> {s,all-ones,0}, overflow=1, inexact=1.
//  Final e <= 0 -> {s,0,0} (flush), underflow=1, inexact=1.
//  i_a/i_b ignored while not accepting; i_valid deassert mid-op has no effect.
// CONFIGURATION
//  FPU_MUL_FLAGS_EN defined: o_flags port and flag logic present, flags update with o_result, reset 0.
//  Undefined: o_flags port absent, no flag registers; o_result identical in both builds.
// TESTING (EXP_BITS=8, MAN_BITS=23, RADIX_BITS=4)
//  0x3FC00000*0x40000000 -> 0x40400000, flags 0, o_valid exactly 10 cycles after accept.
//  0x3F800001*0x3F800001 -> 0x3F800002, inexact=1 (RNE with sticky).
//  0x7F000000*0x7F000000 -> 0x7F800000 ovf+inex; 0x00800000*0x3F000000 -> 0x00000000 unf+inex.
//  0x00000000*0x7F800000 -> 0x7FC00000 invalid=1; 0xFF800000*0x40000000 -> 0xFF800000, latency 2.
//  Hold i_ready=0 5 cycles in DONE -> o_result stable, o_ready=0; raise with i_valid -> next op accepted same cycle.
//  Assert i_rst in MULT cycle 3 -> next cycle IDLE, o_valid=0, o_ready=1, no result emitted.

Source files
------------

// File: rtl/fp_mul_iter.sv
// Iterative floating-point multiplier with valid/ready handshakes.
// Radix-2^RADIX_BITS mantissa multiply, round-to-nearest-even, flush-to-zero
// for subnormal inputs and underflowing results.
// Optional build macro: FPU_MUL_FLAGS_EN adds the o_flags port
// {invalid, overflow, underflow, inexact}; o_result is the same either way.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for operands
// S_CLASS | classify operands; specials finish here, else set up multiply
// S_MULT  | retire RADIX_BITS multiplier bits per cycle
// S_NORM  | normalise product, extract guard and sticky
// S_ROUND | round to nearest even, range check exponent
// S_DONE  | result valid, held until consumer accepts
module fp_mul_iter #(
   parameter int EXP_BITS   = 8,
   parameter int MAN_BITS   = 23,
   parameter int RADIX_BITS = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [EXP_BITS+MAN_BITS:0] i_a,
   input  logic [EXP_BITS+MAN_BITS:0] i_b,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [EXP_BITS+MAN_BITS:0] o_result
`ifdef FPU_MUL_FLAGS_EN
   ,
   output logic [3:0]                 o_flags
`endif
);

   localparam int W     = 1 + EXP_BITS + MAN_BITS;
   localparam int EW    = EXP_BITS + 2;
   localparam int ACC_W = 2*MAN_BITS + 2;
   localparam int N     = (MAN_BITS + RADIX_BITS) / RADIX_BITS;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;

   localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_BITS-1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_BITS) - 1);
   localparam logic signed [EW-1:0] EONE = EW'(1);
   localparam logic signed [EW-1:0] EZRO = EW'(0);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_CLASS, S_MULT, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [W-1:0]          a_q, a_d, b_q, b_d, res_q, res_d;
   logic                  s_q, s_d;
   logic signed [EW-1:0]  e_q, e_d;
   logic [ACC_W-1:0]      acc_q, acc_d, mand_q, mand_d;
   logic [MAN_BITS:0]     mb_q, mb_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [MAN_BITS-1:0]   frac_q, frac_d;
   logic                  g_q, g_d, st_q, st_d;
`ifdef FPU_MUL_FLAGS_EN
   logic [3:0]            flg_q, flg_d;
`endif

   logic [EXP_BITS-1:0]   ex, ey;
   logic [MAN_BITS-1:0]   mx, my;
   logic                  zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
   logic                  up;
   logic [MAN_BITS:0]     rsum;
   logic signed [EW-1:0]  e_r;
   logic [ACC_W-1:0]      chunk;

   assign ex     = a_q[W-2:MAN_BITS];
   assign ey     = b_q[W-2:MAN_BITS];
   assign mx     = a_q[MAN_BITS-1:0];
   assign my     = b_q[MAN_BITS-1:0];
   assign zero_x = (ex == '0);
   assign zero_y = (ey == '0);
   assign inf_x  = (&ex) & (mx == '0);
   assign inf_y  = (&ey) & (my == '0);
   assign nan_x  = (&ex) & (mx != '0);
   assign nan_y  = (&ey) & (my != '0);

   assign chunk  = {{(ACC_W-RADIX_BITS){1'b0}}, mb_q[RADIX_BITS-1:0]};
   assign up     = g_q & (st_q | frac_q[0]);
   assign rsum   = {1'b0, frac_q} + {{MAN_BITS{1'b0}}, up};
   assign e_r    = e_q + {{(EW-1){1'b0}}, rsum[MAN_BITS]};

   assign o_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & i_ready);
   assign o_valid  = (state_q == S_DONE);
   assign o_result = res_q;
`ifdef FPU_MUL_FLAGS_EN
   assign o_flags  = flg_q;
`endif

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         s_q     <= 1'b0;
         e_q     <= '0;
         acc_q   <= '0;
         mand_q  <= '0;
         mb_q    <= '0;
         cnt_q   <= '0;
         frac_q  <= '0;
         g_q     <= 1'b0;
         st_q    <= 1'b0;
`ifdef FPU_MUL_FLAGS_EN
         flg_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         s_q     <= s_d;
         e_q     <= e_d;
         acc_q   <= acc_d;
         mand_q  <= mand_d;
         mb_q    <= mb_d;
         cnt_q   <= cnt_d;
         frac_q  <= frac_d;
         g_q     <= g_d;
         st_q    <= st_d;
`ifdef FPU_MUL_FLAGS_EN
         flg_q   <= flg_d;
`endif
      end
   end

   // Next-state and datapath updates for each phase of the operation.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      s_d     = s_q;
      e_d     = e_q;
      acc_d   = acc_q;
      mand_d  = mand_q;
      mb_d    = mb_q;
      cnt_d   = cnt_q;
      frac_d  = frac_q;
      g_d     = g_q;
      st_d    = st_q;
`ifdef FPU_MUL_FLAGS_EN
      flg_d   = flg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               a_d     = i_a;
               b_d     = i_b;
               state_d = S_CLASS;
            end
         end
         S_CLASS: begin
            s_d = a_q[W-1] ^ b_q[W-1];
            if (nan_x | nan_y | (zero_x & inf_y) | (inf_x & zero_y)) begin
               res_d   = QNAN;
               state_d = S_DONE;
`ifdef FPU_MUL_FLAGS_EN
               flg_d   = 4'b1000;
`endif
            end else if (inf_x | inf_y) begin
               res_d   = {a_q[W-1] ^ b_q[W-1], {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
               state_d = S_DONE;
`ifdef FPU_MUL_FLAGS_EN
               flg_d   = 4'b0000;
`endif
            end else if (zero_x | zero_y) begin
               res_d   = {a_q[W-1] ^ b_q[W-1], {(W-1){1'b0}}};
               state_d = S_DONE;
`ifdef FPU_MUL_FLAGS_EN
               flg_d   = 4'b0000;
`endif
            end else begin
               e_d     = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;
               acc_d   = '0;
               mand_d  = {{(ACC_W-MAN_BITS-1){1'b0}}, 1'b1, mx};
               mb_d    = {1'b1, my};
               cnt_d   = CW'(N - 1);
               state_d = S_MULT;
            end
         end
         S_MULT: begin
            acc_d  = acc_q + mand_q * chunk;
            mand_d = mand_q << RADIX_BITS;
            mb_d   = mb_q >> RADIX_BITS;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = S_NORM;
         end
         S_NORM: begin
            if (acc_q[ACC_W-1]) begin
               e_d    = e_q + EONE;
               frac_d = acc_q[2*MAN_BITS:MAN_BITS+1];
               g_d    = acc_q[MAN_BITS];
               st_d   = |acc_q[MAN_BITS-1:0];
            end else begin
               frac_d = acc_q[2*MAN_BITS-1:MAN_BITS];
               g_d    = acc_q[MAN_BITS-1];
               st_d   = |acc_q[MAN_BITS-2:0];
            end
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (e_r >= EMAX) begin
               res_d = {s_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
`ifdef FPU_MUL_FLAGS_EN
               flg_d = 4'b0101;
`endif
            end else if (e_r <= EZRO) begin
               res_d = {s_q, {(W-1){1'b0}}};
`ifdef FPU_MUL_FLAGS_EN
               flg_d = 4'b0011;
`endif
            end else begin
               res_d = {s_q, e_r[EXP_BITS-1:0], rsum[MAN_BITS-1:0]};
`ifdef FPU_MUL_FLAGS_EN
               flg_d = {3'b000, g_q | st_q};
`endif
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (i_ready) begin
               if (i_valid) begin
                  a_d     = i_a;
                  b_d     = i_b;
                  state_d = S_CLASS;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed testbench for fp_mul_iter in binary32 configuration.
module tb_fp_mul_iter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
`ifdef FPU_MUL_FLAGS_EN
   logic [3:0]  o_flags;
`endif

   int pass_cnt = 0;
   int total    = 0;

   fp_mul_iter #(.EXP_BITS(8), .MAN_BITS(23), .RADIX_BITS(4)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result)
`ifdef FPU_MUL_FLAGS_EN
      ,
      .o_flags  (o_flags)
`endif
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed vectors: a, b, expected result, expected flags, expected latency.
   localparam int NV = 17;
   logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00000, 32'h3FFFFFFF,
                            32'hC0000000, 32'h7F000000, 32'h7F000000, 32'h7F000000,
                            32'h00800000, 32'h00800000, 32'h00000000, 32'hFF800000,
                            32'hFF812345, 32'h7F800000, 32'h80000000, 32'h00000001,
                            32'h3F800000};
   logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF,
                            32'h40400000, 32'h7F000000, 32'h40000000, 32'h3F800000,
                            32'h3F000000, 32'h3F800000, 32'h7F800000, 32'h40000000,
                            32'h3F800000, 32'hFF800000, 32'h40000000, 32'h40000000,
                            32'h3F800000};
   logic [31:0] vr [NV] = '{32'h40400000, 32'h3F800002, 32'h3FC00002, 32'h407FFFFE,
                            32'hC0C00000, 32'h7F800000, 32'h7F800000, 32'h7F000000,
                            32'h00000000, 32'h00800000, 32'h7FC00000, 32'hFF800000,
                            32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000,
                            32'h3F800000};
   logic [3:0]  vf [NV] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
                            4'b0000, 4'b0101, 4'b0101, 4'b0000,
                            4'b0011, 4'b0000, 4'b1000, 4'b0000,
                            4'b1000, 4'b0000, 4'b0000, 4'b0000,
                            4'b0000};
   int          vl [NV] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10,
                            2, 2, 2, 2, 2, 2, 10};

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, output bit ok);
      ok = 1'b0;
      @(negedge i_clk);
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      if (ok) @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_a     = $urandom;
      i_b     = $urandom;
   endtask

   task automatic wait_result(output logic [31:0] r, output logic [3:0] f,
                              output int lat, output bit ok);
      lat = 1;
      ok  = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge i_clk);
         if (o_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge i_clk);
         lat++;
      end
      r = o_result;
`ifdef FPU_MUL_FLAGS_EN
      f = o_flags;
`else
      f = 4'b0000;
`endif
   endtask

   task automatic release_result();
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1 i_ready = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", o_valid); else pass_cnt++;
      total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", o_ready); else pass_cnt++;
      total++; if (o_result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", o_result); else pass_cnt++;
`ifdef FPU_MUL_FLAGS_EN
      total++; if (o_flags !== 4'h0) $display("FAIL reset_flags got=%b want=0000", o_flags); else pass_cnt++;
`endif
      i_rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      bit          ok;
      for (int i = 0; i < NV; i++) begin
         start_op(va[i], vb[i], ok);
         if (!ok) begin
            total++; $display("FAIL vec%0d_accept got=timeout want=accepted", i);
            continue;
         end
         wait_result(r, f, lat, ok);
         if (!ok) begin
            total++; $display("FAIL vec%0d_valid got=timeout want=o_valid", i);
            continue;
         end
         total++; if (r !== vr[i]) $display("FAIL vec%0d_result %h*%h got=%h want=%h", i, va[i], vb[i], r, vr[i]); else pass_cnt++;
         total++; if (lat !== vl[i]) $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, vl[i]); else pass_cnt++;
`ifdef FPU_MUL_FLAGS_EN
         total++; if (f !== vf[i]) $display("FAIL vec%0d_flags got=%b want=%b", i, f, vf[i]); else pass_cnt++;
`endif
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      bit          ok;
      start_op(32'h40400000, 32'h40000000, ok);
      wait_result(r, f, lat, ok);
      total++; if (!ok || r !== 32'h40C00000) $display("FAIL b2b_first got=%h ok=%0d want=40c00000", r, ok); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         total++; if (o_result !== 32'h40C00000 || o_valid !== 1'b1)
            $display("FAIL b2b_hold%0d got=%h/%b want=40c00000/1", c, o_result, o_valid); else pass_cnt++;
         total++; if (o_ready !== 1'b0) $display("FAIL b2b_ready_low%0d got=%b want=0", c, o_ready); else pass_cnt++;
      end
      i_ready = 1'b1; i_valid = 1'b1; i_a = 32'hC0000000; i_b = 32'h40400000;
      #1;
      total++; if (o_ready !== 1'b1) $display("FAIL b2b_ready_high got=%b want=1", o_ready); else pass_cnt++;
      @(posedge i_clk);
      #1 i_valid = 1'b0; i_ready = 1'b0; i_a = $urandom; i_b = $urandom;
      total++; if (o_valid !== 1'b0) $display("FAIL b2b_valid_drop got=%b want=0", o_valid); else pass_cnt++;
      wait_result(r, f, lat, ok);
      total++; if (!ok || r !== 32'hC0C00000) $display("FAIL b2b_second got=%h ok=%0d want=c0c00000", r, ok); else pass_cnt++;
      total++; if (lat !== 10) $display("FAIL b2b_latency got=%0d want=10", lat); else pass_cnt++;
      release_result();
   endtask

   task automatic test_reset_midop();
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      bit          ok;
      bit          seen;
      start_op(32'h3FC00000, 32'h40000000, ok);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      total++; if (o_valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", o_valid); else pass_cnt++;
      total++; if (o_ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", o_ready); else pass_cnt++;
      @(negedge i_clk);
      i_rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge i_clk);
         if (o_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL midrst_no_output got=%b want=0", seen); else pass_cnt++;
      start_op(32'h3FC00000, 32'h40000000, ok);
      wait_result(r, f, lat, ok);
      total++; if (!ok || r !== 32'h40400000 || lat !== 10)
         $display("FAIL midrst_recover got=%h lat=%0d want=40400000 lat=10", r, lat); else pass_cnt++;
      release_result();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
